// File: rtl/i2c_bus_monitor_if.sv
// Pad-side and monitor-side view of the I2C receive monitor signals.
// The slave modport is the monitor itself; the master modport is whoever drives the pads and consumes the events.
interface i2c_bus_monitor_if #(
   parameter int CNT_W = 8
) ();

   logic             scl_in;
   logic             sda_in;
   logic             scl_f;
   logic             sda_f;
   logic             scl_rise;
   logic             scl_fall;
   logic             start_det;
   logic             stop_det;
   logic             bus_busy;
   logic [CNT_W-1:0] measHi;
   logic [CNT_W-1:0] measLo;
   logic             measHiVld;
   logic             measLoVld;

   modport slave (
      input  scl_in,
      input  sda_in,
      output scl_f,
      output sda_f,
      output scl_rise,
      output scl_fall,
      output start_det,
      output stop_det,
      output bus_busy,
      output measHi,
      output measLo,
      output measHiVld,
      output measLoVld
   );

   modport master (
      output scl_in,
      output sda_in,
      input  scl_f,
      input  sda_f,
      input  scl_rise,
      input  scl_fall,
      input  start_det,
      input  stop_det,
      input  bus_busy,
      input  measHi,
      input  measLo,
      input  measHiVld,
      input  measLoVld
   );

endinterface

// File: rtl/i2c_bus_monitor.sv
// I2C receive-side monitor: synchronises and glitch-filters SCL/SDA, flags edges and START/STOP,
// tracks bus-busy and measures completed SCL high/low phase lengths in clk cycles.
module i2c_bus_monitor #(
   parameter int FILT_LEN = 3,
   parameter int CNT_W    = 8
) (
   input logic               clk,
   input logic               rst_an,
   i2c_bus_monitor_if.slave  bus
);

   localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // After reset the line levels must be re-acquired before START/STOP may be reported,
   // otherwise a bus held with SDA low would look like a fresh START.
   typedef enum logic [1:0] {
      ACQ_FILL1,
      ACQ_FILL2,
      ACQ_SETTLE,
      ACQ_ARMED
   } acqState_t;

   acqState_t        acqState;
   acqState_t        acqNext;
   logic             armed;

   logic [1:0]       syncA;
   logic [1:0]       syncB;
   logic [1:0]       filt;
   logic [3:0]       filtCnt [2];

   logic             sclQ;
   logic             sdaQ;
   logic             sclF;
   logic             sdaF;
   logic             sclRise;
   logic             sclFall;
   logic             startDet;
   logic             stopDet;

   logic             busBusy;
   logic [CNT_W-1:0] periodCnt;
   logic             seenRise;
   logic             seenFall;
   logic [CNT_W-1:0] measHiReg;
   logic [CNT_W-1:0] measLoReg;
   logic             measHiVldReg;
   logic             measLoVldReg;

   // Bit 0 carries SCL, bit 1 carries SDA: two-flop synchroniser, then a per-line
   // persistence filter that only accepts a level held for FILT_LEN cycles.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         syncA      <= 2'b11;
         syncB      <= 2'b11;
         filt       <= 2'b11;
         filtCnt[0] <= '0;
         filtCnt[1] <= '0;
      end else begin
         syncA <= {bus.sda_in, bus.scl_in};
         syncB <= syncA;
         for (int i = 0; i < 2; i++) begin
            if (syncB[i] != filt[i]) begin
               if (filtCnt[i] == FILT_MAX) begin
                  filt[i]    <= syncB[i];
                  filtCnt[i] <= '0;
               end else begin
                  filtCnt[i] <= filtCnt[i] + 4'd1;
               end
            end else begin
               filtCnt[i] <= '0;
            end
         end
      end
   end

   assign sclF = filt[0];
   assign sdaF = filt[1];

   // Acquisition state register.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         acqState <= ACQ_FILL1;
      end else begin
         acqState <= acqNext;
      end
   end

   // Wait for the synchroniser to fill, then for both filtered lines to agree with it.
   always_comb begin
      acqNext = acqState;
      armed   = 1'b0;
      case (acqState)
         ACQ_FILL1:  acqNext = ACQ_FILL2;
         ACQ_FILL2:  acqNext = ACQ_SETTLE;
         ACQ_SETTLE: begin
            if (syncB == filt) begin
               acqNext = ACQ_ARMED;
            end
         end
         ACQ_ARMED:  armed = 1'b1;
         default:    acqNext = ACQ_FILL1;
      endcase
   end

   // Previous filtered levels for edge and START/STOP detection.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         sclQ <= 1'b1;
         sdaQ <= 1'b1;
      end else begin
         sclQ <= sclF;
         sdaQ <= sdaF;
      end
   end

   // SCL must be high in both cycles so a simultaneous SCL/SDA change is never a START/STOP.
   assign sclRise  = sclF & ~sclQ;
   assign sclFall  = ~sclF & sclQ;
   assign startDet = armed & sclF & sclQ & sdaQ & ~sdaF;
   assign stopDet  = armed & sclF & sclQ & ~sdaQ & sdaF;

   // Bus-busy tracking and the saturating SCL phase counter with its captures.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         busBusy      <= 1'b0;
         periodCnt    <= '0;
         seenRise     <= 1'b0;
         seenFall     <= 1'b0;
         measHiReg    <= '0;
         measLoReg    <= '0;
         measHiVldReg <= 1'b0;
         measLoVldReg <= 1'b0;
      end else begin
         if (startDet) begin
            busBusy <= 1'b1;
         end else if (stopDet) begin
            busBusy <= 1'b0;
         end

         if (sclRise || sclFall) begin
            periodCnt <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else if (periodCnt != CNT_MAX) begin
            periodCnt <= periodCnt + 1'b1;
         end

         seenRise     <= seenRise | sclRise;
         seenFall     <= seenFall | sclFall;
         measHiVldReg <= sclFall & seenRise;
         measLoVldReg <= sclRise & seenFall;
         if (sclFall && seenRise) begin
            measHiReg <= periodCnt;
         end
         if (sclRise && seenFall) begin
            measLoReg <= periodCnt;
         end
      end
   end

   assign bus.scl_f     = sclF;
   assign bus.sda_f     = sdaF;
   assign bus.scl_rise  = sclRise;
   assign bus.scl_fall  = sclFall;
   assign bus.start_det = startDet;
   assign bus.stop_det  = stopDet;
   assign bus.bus_busy  = busBusy;
   assign bus.measHi    = measHiReg;
   assign bus.measLo    = measLoReg;
   assign bus.measHiVld = measHiVldReg;
   assign bus.measLoVld = measLoVldReg;

endmodule
